bin_to_gray_counter: RTL and testbench

- Up/down binary counter that drives a registered, glitch-free Gray-coded output. It is the encode side paired with the team's Gray-to-binary converter.
- Used wherever a count must cross into another domain or be compared bit-serially: FIFO pointers, position counters.
- Supports a parallel binary load, a count enable, a direction select, a terminal-count flag and a one-cycle wrap pulse.

---
 rtl/bin_to_gray_counter.sv | 113 +++++++++++
 tb/tb_bin_to_gray_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a registered Gray-coded output, load, terminal count and wrap pulse.
// Optional Gray single-step self-check is enabled by defining GRAY_CHK_EN.
module bin_to_gray_counter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [N-1:0] din,
  input  logic         en,
  input  logic         up,
  output logic [N-1:0] bin,
  output logic [N-1:0] gray,
  output logic         tc,
  output logic         wrap,
  output logic         err
);

  localparam logic [N-1:0] AllOnes = {N{1'b1}};
  localparam logic [N-1:0] Zero    = '0;
  localparam logic [N-1:0] One     = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] bin_q, bin_d;
  logic [N-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;
  logic         step;
  logic         at_top, at_bottom;

  assign step      = ~ld & en;
  assign at_top    = (bin_q == AllOnes);
  assign at_bottom = (bin_q == Zero);

  // Flags that the next enabled step crosses the end of the range.
  assign tc = en & ((up & at_top) | (~up & at_bottom));

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (ld) begin
      bin_d = din;
    end else if (en) begin
      bin_d  = up ? (bin_q + One) : (bin_q - One);
      wrap_d = tc;
    end
  end

  // Gray is encoded from the next binary value so both registers update together.
  assign gray_d = bin_d ^ (bin_d >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

`ifdef GRAY_CHK_EN
  logic [N-1:0] prev_gray_q;
  logic         step_q;
  logic         skip_q;
  logic         loaded_q, loaded_d;
  logic         err_q, err_d;
  logic [N-1:0] diff;
  logic         one_hot;

  assign diff = gray_q ^ prev_gray_q;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign one_hot = (diff != Zero) && ((diff & (diff - One)) == Zero);

  // A load leaves the next step unchecked; cleared once that step has happened.
  always_comb begin
    loaded_d = loaded_q;
    if (ld) begin
      loaded_d = 1'b1;
    end else if (en) begin
      loaded_d = 1'b0;
    end
  end

  assign err_d = err_q | (step_q & ~skip_q & ~one_hot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_q <= '0;
      step_q      <= 1'b0;
      skip_q      <= 1'b0;
      loaded_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_gray_q <= gray_q;
      step_q      <= step;
      skip_q      <= step & loaded_q;
      loaded_q    <= loaded_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Directed-vector bench for bin_to_gray_counter (N = 4), with async-reset and sweep sequences.
module tb_bin_to_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld;
  logic [3:0] din;
  logic       en;
  logic       up;
  logic [3:0] bin;
  logic [3:0] gray;
  logic       tc;
  logic       wrap;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       ld;
    logic [3:0] din;
    logic       en;
    logic       up;
    logic       tc;    // expected before the edge
    logic [3:0] bin;   // expected after the edge
    logic [3:0] gray;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  bin_to_gray_counter #(.N(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (ld),
    .din  (din),
    .en   (en),
    .up   (up),
    .bin  (bin),
    .gray (gray),
    .tc   (tc),
    .wrap (wrap),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(logic l, logic [3:0] d, logic e, logic u, logic t,
                             logic [3:0] b, logic [3:0] g, logic w);
    vec_t r;
    r.ld = l; r.din = d; r.en = e; r.up = u; r.tc = t; r.bin = b; r.gray = g; r.wrap = w;
    return r;
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic drive(input logic l, input logic [3:0] d, input logic e, input logic u);
    ld = l; din = d; en = e; up = u;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcount4(logic [3:0] x);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(x[i]);
    return c;
  endfunction

  initial begin
    logic [3:0] b, prev_g, exp_g;
    logic       exp_w, dir;

    // ld din en up | tc | bin gray wrap
    vecs.push_back(v(0, 4'h0, 0, 1, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'h0, 0, 1, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'h0, 0, 1, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(1, 4'b0101, 0, 1, 0, 4'b0101, 4'b0111, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 0, 4'b0110, 4'b0101, 0));
    vecs.push_back(v(1, 4'b0111, 0, 1, 0, 4'b0111, 4'b0100, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 0, 4'b1000, 4'b1100, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 0, 4'b1001, 4'b1101, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 0, 4'b1010, 4'b1111, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 0, 4'b1011, 4'b1110, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 0, 4'b1100, 4'b1010, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 0, 4'b1101, 4'b1011, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 0, 4'b1110, 4'b1001, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 0, 4'b1111, 4'b1000, 0));
    vecs.push_back(v(0, 4'h0, 1, 1, 1, 4'b0000, 4'b0000, 1));
    vecs.push_back(v(0, 4'h0, 0, 1, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'h0, 1, 0, 1, 4'b1111, 4'b1000, 1));
    vecs.push_back(v(0, 4'h0, 1, 1, 1, 4'b0000, 4'b0000, 1));
    vecs.push_back(v(1, 4'b1010, 1, 1, 0, 4'b1010, 4'b1111, 0));
    vecs.push_back(v(1, 4'b1111, 1, 0, 0, 4'b1111, 4'b1000, 0));
    // tc is raised but the load wins and must not pulse wrap.
    vecs.push_back(v(1, 4'b0011, 1, 1, 1, 4'b0011, 4'b0010, 0));
    vecs.push_back(v(0, 4'h0, 1, 0, 0, 4'b0010, 4'b0011, 0));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 4'b0010, 4'b0011, 0));

    rst_n = 1'b0;
    ld = 0; din = '0; en = 0; up = 1;
    #12;
    chk("reset_bin", 32'(bin), 32'h0);
    chk("reset_gray", 32'(gray), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].din, vecs[i].en, vecs[i].up);
      chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].tc));
      tick();
      chk($sformatf("vec%0d_bin", i), 32'(bin), 32'(vecs[i].bin));
      chk($sformatf("vec%0d_gray", i), 32'(gray), 32'(vecs[i].gray));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].wrap));
    end

    // Wrap pulse pending, then asynchronous reset between edges.
    drive(1, 4'b1111, 0, 1);
    tick();
    drive(0, 4'h0, 1, 1);
    tick();
    chk("pre_rst_wrap", 32'(wrap), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_bin", 32'(bin), 32'h0);
    chk("async_rst_gray", 32'(gray), 32'h0);
    chk("async_rst_wrap", 32'(wrap), 32'h0);
    tick();
    chk("rst_held_bin", 32'(bin), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("first_count_bin", 32'(bin), 32'h1);
    chk("first_count_gray", 32'(gray), 32'h1);

    // 32-step sweep from 0: 16 up (ending in a wrap), then 16 down (starting with a wrap).
    drive(1, 4'b0000, 0, 1);
    tick();
    b = 4'b0000;
    prev_g = gray;
    for (int i = 0; i < 32; i++) begin
      dir = (i < 16);
      drive(0, 4'h0, 1, dir);
      exp_w = dir ? (b == 4'hF) : (b == 4'h0);
      chk($sformatf("sweep%0d_tc", i), 32'(tc), 32'(exp_w));
      tick();
      b = dir ? b + 4'd1 : b - 4'd1;
      exp_g = b ^ (b >> 1);
      chk($sformatf("sweep%0d_bin", i), 32'(bin), 32'(b));
      chk($sformatf("sweep%0d_gray", i), 32'(gray), 32'(exp_g));
      chk($sformatf("sweep%0d_onebit", i), 32'(popcount4(gray ^ prev_g)), 32'd1);
      chk($sformatf("sweep%0d_wrap", i), 32'(wrap), 32'(exp_w));
      prev_g = gray;
    end
    drive(0, 4'h0, 0, 1);
    tick();
    chk("sweep_err", 32'(err), 32'h0);

`ifdef GRAY_CHK_EN
    // Corrupt gray right after an enabled 0 -> 1 step; the checker must latch err.
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 4'h0, 1, 1);
    tick();
    force dut.gray_q = 4'b0111;
    drive(0, 4'h0, 0, 1);
    tick();
    release dut.gray_q;
    chk("chk_err_set", 32'(err), 32'h1);
    tick();
    tick();
    chk("chk_err_sticky", 32'(err), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("chk_err_cleared", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
